// File: rtl/instruction_fetch.sv
// instruction_fetch: holds the PC and runs one imem req/ack fetch per phase_fetch, feeding decode.
// Optional misaligned-jump trap is built when ROCKWAVE_FETCH_MISALIGN_CHECK_EN is defined.
module instruction_fetch #(
  parameter int unsigned       XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0]   TRAP_VECTOR  = 32'h0000_0004,
  parameter int unsigned       TIMEOUT_CYC  = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            phase_fetch,
  input  logic            pc_update,
  input  logic            jump_taken,
  input  logic [XLEN-1:0] jump_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] curr_pc_fd,
  output logic [XLEN-1:0] next_pc_fd,
  output logic            fetch_busy,
  output logic            fetch_err,
  output logic            misalign_err
);

  localparam logic [31:0]     NOP_INST     = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP      = XLEN'(3'd4);
  localparam logic [7:0]      TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t          state_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_next_s;
  logic [7:0]      wait_cnt_r;

`ifdef ROCKWAVE_FETCH_MISALIGN_CHECK_EN
  logic            misalign_s;

  // Next-PC selection; a misaligned jump target redirects to the trap vector.
  always_comb begin
    pc_next_s  = pc_r;
    misalign_s = 1'b0;
    if (pc_update) begin
      if (jump_taken) begin
        if (jump_pc[1:0] != 2'b00) begin
          pc_next_s  = TRAP_VECTOR;
          misalign_s = 1'b1;
        end else begin
          pc_next_s  = jump_pc;
        end
      end else begin
        pc_next_s = pc_r + PC_STEP;
      end
    end else begin
      pc_next_s = pc_r;
    end
  end

  // Single-cycle misalignment pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= misalign_s;
    end
  end
`else
  logic unused_jump_low_s;

  assign unused_jump_low_s = ^jump_pc[1:0];

  // Next-PC selection; low target bits are dropped to keep the PC word aligned.
  always_comb begin
    pc_next_s = pc_r;
    if (pc_update) begin
      if (jump_taken) begin
        pc_next_s = {jump_pc[XLEN-1:2], 2'b00};
      end else begin
        pc_next_s = pc_r + PC_STEP;
      end
    end else begin
      pc_next_s = pc_r;
    end
  end

  assign misalign_err = 1'b0;
`endif

  // Fetch FSM, PC register and all registered decode-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      pc_r       <= RESET_VECTOR;
      wait_cnt_r <= 8'd0;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_VECTOR;
      inst       <= NOP_INST;
      curr_pc_fd <= RESET_VECTOR;
      next_pc_fd <= RESET_VECTOR;
      fetch_busy <= 1'b0;
      fetch_err  <= 1'b0;
    end else begin
      pc_r      <= pc_next_s;
      fetch_err <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // A simultaneous pc_update takes priority and the fetch is dropped.
          if (phase_fetch && !pc_update) begin
            state_r    <= ST_REQ;
            imem_req   <= 1'b1;
            imem_addr  <= pc_r;
            fetch_busy <= 1'b1;
            wait_cnt_r <= 8'd0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          // The request uses the latched imem_addr, so pc_update here only affects the next fetch.
          if (imem_ack) begin
            state_r    <= ST_IDLE;
            imem_req   <= 1'b0;
            fetch_busy <= 1'b0;
            inst       <= imem_rdata;
            curr_pc_fd <= imem_addr;
            next_pc_fd <= imem_addr + PC_STEP;
          end else if (wait_cnt_r == TIMEOUT_LAST) begin
            state_r    <= ST_IDLE;
            imem_req   <= 1'b0;
            fetch_busy <= 1'b0;
            inst       <= NOP_INST;
            curr_pc_fd <= imem_addr;
            next_pc_fd <= imem_addr + PC_STEP;
            fetch_err  <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          imem_req   <= 1'b0;
          fetch_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed table, hand sequences and
// randomized transactions checked against a transaction-level PC/fetch model.
module tb_instruction_fetch;

  localparam int          TO   = 4;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] TRAP = 32'h0000_0004;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        phase_fetch = 1'b0;
  logic        pc_update = 1'b0;
  logic        jump_taken = 1'b0;
  logic [31:0] jump_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] inst;
  logic [31:0] curr_pc_fd;
  logic [31:0] next_pc_fd;
  logic        fetch_busy;
  logic        fetch_err;
  logic        misalign_err;

  instruction_fetch #(
    .XLEN(32), .RESET_VECTOR(32'h0000_0000), .TRAP_VECTOR(TRAP), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .phase_fetch(phase_fetch), .pc_update(pc_update),
    .jump_taken(jump_taken), .jump_pc(jump_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst), .curr_pc_fd(curr_pc_fd),
    .next_pc_fd(next_pc_fd), .fetch_busy(fetch_busy), .fetch_err(fetch_err),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl_pc;
  logic [31:0] mdl_inst;
  logic [31:0] mdl_curr;
  logic [31:0] mdl_next;
  logic        last_err;

  typedef struct {
    int          n_seq;
    logic        do_jump;
    logic [31:0] jpc;
    int          ack;
    logic [31:0] rdata;
    logic        exp_mis;
    logic [31:0] exp_addr;
    logic [31:0] exp_inst;
    logic [31:0] exp_next;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_update(input logic jt, input logic [31:0] jp, output logic mis);
    mis = 1'b0;
    if (!jt) begin
      mdl_pc = mdl_pc + 32'd4;
    end else begin
`ifdef ROCKWAVE_FETCH_MISALIGN_CHECK_EN
      if (jp[1:0] != 2'b00) begin
        mdl_pc = TRAP;
        mis    = 1'b1;
      end else begin
        mdl_pc = jp;
      end
`else
      mdl_pc = jp & 32'hFFFF_FFFC;
`endif
    end
  endtask

  task automatic model_reset();
    mdl_pc   = 32'h0;
    mdl_inst = NOP;
    mdl_curr = 32'h0;
    mdl_next = 32'h0;
  endtask

  task automatic do_update(input logic jt, input logic [31:0] jp, input logic with_fetch);
    logic mis;
    model_update(jt, jp, mis);
    pc_update = 1'b1; jump_taken = jt; jump_pc = jp; phase_fetch = with_fetch;
    step();
    pc_update = 1'b0; jump_taken = 1'b0; phase_fetch = 1'b0;
    chk("misalign_err", {31'b0, misalign_err}, {31'b0, mis});
    if (with_fetch) begin
      chk("dropped_fetch_req", {31'b0, imem_req}, 32'h0);
      chk("dropped_fetch_busy", {31'b0, fetch_busy}, 32'h0);
    end
  endtask

  // One fetch transaction: ack after ack_delay REQ cycles (0 = never), optional pc_update mid-REQ.
  task automatic run_fetch(input int ack_delay, input logic [31:0] rdata, input int upd_cycle,
                           input logic upd_jt, input logic [31:0] upd_pc, input logic ph_noise);
    logic [31:0] exp_addr;
    logic        mis;
    logic        done;
    exp_addr = mdl_pc;
    done = 1'b0;
    phase_fetch = 1'b1;
    step();
    phase_fetch = 1'b0;
    chk("req_start", {31'b0, imem_req}, 32'h1);
    chk("addr_start", imem_addr, exp_addr);
    chk("busy_start", {31'b0, fetch_busy}, 32'h1);
    for (int k = 1; k <= TO + 1 && !done; k++) begin
      mis = 1'b0;
      imem_ack    = (k == ack_delay);
      imem_rdata  = (k == ack_delay) ? rdata : $urandom;
      phase_fetch = ph_noise;
      pc_update   = (k == upd_cycle);
      jump_taken  = upd_jt;
      jump_pc     = upd_pc;
      if (k == upd_cycle) model_update(upd_jt, upd_pc, mis);
      step();
      imem_ack = 1'b0; phase_fetch = 1'b0; pc_update = 1'b0; jump_taken = 1'b0;
      if (k == upd_cycle) chk("misalign_in_req", {31'b0, misalign_err}, {31'b0, mis});
      if (k == ack_delay) begin
        mdl_inst = rdata; mdl_curr = exp_addr; mdl_next = exp_addr + 32'd4;
        chk("no_err_on_ack", {31'b0, fetch_err}, 32'h0);
        last_err = 1'b0;
        done = 1'b1;
      end else if (k == TO) begin
        mdl_inst = NOP; mdl_curr = exp_addr; mdl_next = exp_addr + 32'd4;
        chk("timeout_err", {31'b0, fetch_err}, 32'h1);
        last_err = 1'b1;
        done = 1'b1;
      end else begin
        chk("req_held", {31'b0, imem_req}, 32'h1);
        chk("addr_held", imem_addr, exp_addr);
        chk("busy_held", {31'b0, fetch_busy}, 32'h1);
        chk("no_err_wait", {31'b0, fetch_err}, 32'h0);
      end
    end
    chk("timeout_bound", {31'b0, done}, 32'h1);
    chk("inst", inst, mdl_inst);
    chk("curr_pc_fd", curr_pc_fd, mdl_curr);
    chk("next_pc_fd", next_pc_fd, mdl_next);
    chk("req_done", {31'b0, imem_req}, 32'h0);
    chk("busy_done", {31'b0, fetch_busy}, 32'h0);
    imem_ack = 1'b1; imem_rdata = ~mdl_inst;
    step();
    imem_ack = 1'b0;
    chk("idle_ack_inst", inst, mdl_inst);
    chk("idle_ack_req", {31'b0, imem_req}, 32'h0);
    chk("err_pulse_end", {31'b0, fetch_err}, 32'h0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, {31'b0, imem_req}, 32'h0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_inst"}, inst, NOP);
    chk({tag, "_curr"}, curr_pc_fd, 32'h0);
    chk({tag, "_next"}, next_pc_fd, 32'h0);
    chk({tag, "_busy"}, {31'b0, fetch_busy}, 32'h0);
    chk({tag, "_ferr"}, {31'b0, fetch_err}, 32'h0);
    chk({tag, "_merr"}, {31'b0, misalign_err}, 32'h0);
  endtask

  initial begin
    vecs[0] = '{0, 1'b0, 32'h0, 1, 32'h0050_0093, 1'b0, 32'h0000_0000, 32'h0050_0093, 32'h0000_0004, 1'b0};
    vecs[1] = '{3, 1'b0, 32'h0, 4, 32'h1234_5678, 1'b0, 32'h0000_000C, 32'h1234_5678, 32'h0000_0010, 1'b0};
    vecs[2] = '{0, 1'b1, 32'h100, 2, 32'hA5A5_0001, 1'b0, 32'h0000_0100, 32'hA5A5_0001, 32'h0000_0104, 1'b0};
    vecs[3] = '{0, 1'b0, 32'h0, 0, 32'h0, 1'b0, 32'h0000_0100, NOP, 32'h0000_0104, 1'b1};
    vecs[4] = '{1, 1'b0, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0000_0108, 1'b0};
`ifdef ROCKWAVE_FETCH_MISALIGN_CHECK_EN
    vecs[5] = '{0, 1'b1, 32'h102, 1, 32'h0000_0001, 1'b1, TRAP, 32'h0000_0001, TRAP + 32'd4, 1'b0};
`else
    vecs[5] = '{0, 1'b1, 32'h102, 1, 32'h0000_0001, 1'b0, 32'h0000_0100, 32'h0000_0001, 32'h0000_0104, 1'b0};
`endif
    vecs[6] = '{0, 1'b1, 32'hFFFF_FFFC, 2, 32'hCAFE_F00D, 1'b0, 32'hFFFF_FFFC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
    vecs[7] = '{1, 1'b0, 32'h0, 1, 32'h1111_2222, 1'b0, 32'h0000_0000, 32'h1111_2222, 32'h0000_0004, 1'b0};

    model_reset();
    last_err = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      for (int s = 0; s < vecs[i].n_seq; s++) do_update(1'b0, 32'h0, 1'b0);
      if (vecs[i].do_jump) begin
        do_update(1'b1, vecs[i].jpc, 1'b0);
        chk("tbl_misalign", {31'b0, misalign_err}, {31'b0, vecs[i].exp_mis});
      end
      run_fetch(vecs[i].ack, vecs[i].rdata, 0, 1'b0, 32'h0, 1'b0);
      chk("tbl_curr", curr_pc_fd, vecs[i].exp_addr);
      chk("tbl_inst", inst, vecs[i].exp_inst);
      chk("tbl_next", next_pc_fd, vecs[i].exp_next);
      chk("tbl_err", {31'b0, last_err}, {31'b0, vecs[i].exp_err});
    end

    // Jump during an outstanding fetch: capture keeps the old address, next fetch uses the target.
    run_fetch(3, 32'h0BAD_F00D, 1, 1'b1, 32'h200, 1'b1);
    chk("mid_req_jump_curr", curr_pc_fd, 32'h0);
    run_fetch(1, 32'h0000_0093, 0, 1'b0, 32'h0, 1'b0);
    chk("after_jump_curr", curr_pc_fd, 32'h200);

    // phase_fetch together with pc_update: update wins, no request.
    do_update(1'b0, 32'h0, 1'b1);
    run_fetch(2, 32'h7777_0001, 0, 1'b0, 32'h0, 1'b0);
    chk("dropped_then_fetch", curr_pc_fd, 32'h204);

    // Reset in the middle of a request, then a late ack that must be ignored.
    phase_fetch = 1'b1;
    step();
    phase_fetch = 1'b0;
    step();
    #1 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreq_reset");
    rst_n = 1'b1;
    model_reset();
    imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA;
    step();
    imem_ack = 1'b0;
    chk("late_ack_inst", inst, NOP);
    chk("late_ack_req", {31'b0, imem_req}, 32'h0);
    do_update(1'b0, 32'h0, 1'b0);
    run_fetch(1, 32'h0000_0013, 0, 1'b0, 32'h0, 1'b0);
    chk("post_reset_curr", curr_pc_fd, 32'h4);

    for (int it = 0; it < 150; it++) begin
      int          op;
      logic [31:0] jp;
      op = int'($urandom_range(0, 3));
      jp = $urandom;
      if ($urandom_range(0, 1) == 0) jp[1:0] = 2'b00;
      case (op)
        0: do_update(1'($urandom_range(0, 1)), jp, 1'b0);
        1: do_update(1'($urandom_range(0, 1)), jp, 1'b1);
        default: run_fetch(int'($urandom_range(0, 6)), $urandom, int'($urandom_range(0, 5)),
                           1'($urandom_range(0, 1)), jp, 1'($urandom_range(0, 1)));
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
